// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multicycle control unit: 5-state sequencer, instruction decode and memory strobes
module multicycle_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        loadPC,
    output logic [3:0]  ALUCtrl,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;

    logic       is_r;
    logic       is_i;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       bad;
    logic [3:0] alu_op;
    logic       mem_hold;
    logic       unused_bits;

    logic [2:0] funct3;
    logic       alt;

    assign funct3      = instr[14:12];
    assign alt         = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        is_r   = (instr[6:0] == 7'b0110011);
        is_i   = (instr[6:0] == 7'b0010011);
        is_lw  = (instr[6:0] == 7'b0000011);
        is_sw  = (instr[6:0] == 7'b0100011);
        is_beq = (instr[6:0] == 7'b1100011);
        bad    = 1'b0;
        alu_op = ALU_ADD;

        if (is_r || is_i) begin
            // alt selects SUB/SRA; anywhere else it marks an unsupported encoding,
            // except ADDI where bit 30 is just part of the immediate
            case (funct3)
                3'b000: begin
                    alu_op = (is_r && alt) ? ALU_SUB : ALU_ADD;
                end
                3'b001: begin alu_op = ALU_SLL; bad = alt; end
                3'b010: begin alu_op = ALU_SLT; bad = alt; end
                3'b011: begin alu_op = ALU_AND; bad = 1'b1; end
                3'b100: begin alu_op = ALU_XOR; bad = alt; end
                3'b101: begin alu_op = alt ? ALU_SRA : ALU_SRL; end
                3'b110: begin alu_op = ALU_OR;  bad = alt; end
                default: begin alu_op = ALU_AND; bad = alt; end
            endcase
        end else if (is_beq) begin
            alu_op = ALU_SUB;
        end else if (!(is_lw || is_sw)) begin
            bad = 1'b1;
        end

        if (bad) begin
            alu_op = ALU_AND;
        end
    end

    assign mem_hold = (is_lw || is_sw) && (wait_cnt != WAIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IF;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (state == S_MEM && mem_hold) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
        end
    end

    always_comb begin
        state_next = state;
        PCSrc      = 1'b0;
        RegWrite   = 1'b0;
        MemToReg   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        loadPC     = 1'b0;
        illegal    = 1'b0;
        ALUSrc     = is_i || is_lw || is_sw;
        ALUCtrl    = alu_op;

        case (state)
            S_IF:  state_next = S_ID;
            S_ID:  state_next = S_EX;
            S_EX:  state_next = S_MEM;
            S_MEM: begin
                state_next = mem_hold ? S_MEM : S_WB;
                MemRead    = is_lw;
                MemWrite   = is_sw;
                MemToReg   = is_lw;
            end
            S_WB: begin
                state_next = S_IF;
                MemToReg   = is_lw;
                RegWrite   = (is_r || is_i || is_lw) && !bad;
                loadPC     = 1'b1;
                PCSrc      = is_beq && Zero;
                illegal    = bad;
            end
            default: state_next = S_IF;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with MEM_WAIT=2
module tb_multicycle_ctrl;

    localparam int W = 2;

    typedef enum int {C_R, C_I, C_LW, C_SW, C_BEQ, C_ILL} cls_t;
    typedef enum int {T_IF, T_ID, T_EX, T_MEM, T_WB} st_t;

    typedef struct {
        logic [11:0] vec;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        PCSrc;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemToReg;
    logic        MemRead;
    logic        MemWrite;
    logic        loadPC;
    logic [3:0]  ALUCtrl;
    logic        illegal;

    int total;
    int bad;
    exp_t sb[$];

    multicycle_ctrl #(.MEM_WAIT(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .Zero     (Zero),
        .PCSrc    (PCSrc),
        .ALUSrc   (ALUSrc),
        .RegWrite (RegWrite),
        .MemToReg (MemToReg),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .loadPC   (loadPC),
        .ALUCtrl  (ALUCtrl),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] observed();
        return {PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, loadPC, ALUCtrl, illegal};
    endfunction

    // Expected outputs written straight from the control table, per class and state
    function automatic logic [11:0] exp_vec(cls_t c, logic [3:0] alu, logic z, st_t st);
        logic pcsrc, alusrc, regwr, memtoreg, memrd, memwr, loadpc, ill;
        alusrc   = (c == C_I) || (c == C_LW) || (c == C_SW);
        memrd    = (c == C_LW) && (st == T_MEM);
        memwr    = (c == C_SW) && (st == T_MEM);
        memtoreg = (c == C_LW) && (st == T_MEM || st == T_WB);
        regwr    = (c == C_R || c == C_I || c == C_LW) && (st == T_WB);
        loadpc   = (st == T_WB);
        pcsrc    = (c == C_BEQ) && z && (st == T_WB);
        ill      = (c == C_ILL) && (st == T_WB);
        return {pcsrc, alusrc, regwr, memtoreg, memrd, memwr, loadpc, alu, ill};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [11:0] v, input string tag);
        exp_t e;
        e.vec = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq(e.tag, {20'd0, observed()}, {20'd0, e.vec});
        end
    end

    // Entered just after a posedge with the DUT in IF; leaves at the same phase of the next IF
    task automatic run_instr(input string name, input logic [31:0] i, input logic z,
                             input cls_t c, input logic [3:0] alu);
        int n;
        int mw;
        instr = i;
        Zero  = z;
        mw    = (c == C_LW || c == C_SW) ? W : 0;
        n     = 5 + mw;
        push(exp_vec(c, alu, z, T_IF), {name, "_if"});
        push(exp_vec(c, alu, z, T_ID), {name, "_id"});
        push(exp_vec(c, alu, z, T_EX), {name, "_ex"});
        for (int k = 0; k <= mw; k++) begin
            push(exp_vec(c, alu, z, T_MEM), $sformatf("%s_mem%0d", name, k));
        end
        push(exp_vec(c, alu, z, T_WB), {name, "_wb"});
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        instr = 32'h0000_0000;
        Zero  = 1'b0;
        #12;
        check_eq("reset_init", {20'd0, observed()}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_instr("add",    32'h002081B3, 1'b0, C_R,   4'b0010);
        run_instr("srai",   32'h4020D093, 1'b0, C_I,   4'b1010);
        run_instr("sub",    32'h402081B3, 1'b0, C_R,   4'b0110);
        run_instr("or",     32'h0020E1B3, 1'b0, C_R,   4'b0001);
        run_instr("xori",   32'h0050C093, 1'b0, C_I,   4'b1101);
        run_instr("slt",    32'h0020A1B3, 1'b0, C_R,   4'b0111);
        run_instr("slli",   32'h00209093, 1'b0, C_I,   4'b1001);
        run_instr("lw",     32'h00802283, 1'b0, C_LW,  4'b0010);
        run_instr("sw",     32'h00502623, 1'b0, C_SW,  4'b0010);
        run_instr("lw2",    32'h00802283, 1'b1, C_LW,  4'b0010);
        run_instr("beq_z1", 32'h00000463, 1'b1, C_BEQ, 4'b0110);
        run_instr("beq_z0", 32'h00000463, 1'b0, C_BEQ, 4'b0110);
        run_instr("ill_op", 32'h0000007F, 1'b1, C_ILL, 4'b0000);
        run_instr("ill_and",32'h4020F1B3, 1'b0, C_ILL, 4'b0000);

        // Abort a LW in its first MEM cycle
        instr = 32'h00802283;
        Zero  = 1'b0;
        push(exp_vec(C_LW, 4'b0010, 1'b0, T_IF),  "rlw_if");
        push(exp_vec(C_LW, 4'b0010, 1'b0, T_ID),  "rlw_id");
        push(exp_vec(C_LW, 4'b0010, 1'b0, T_EX),  "rlw_ex");
        push(exp_vec(C_LW, 4'b0010, 1'b0, T_MEM), "rlw_mem");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_async", {20'd0, observed()}, {20'd0, exp_vec(C_LW, 4'b0010, 1'b0, T_IF)});
        for (int k = 0; k < 3; k++) begin
            push(exp_vec(C_LW, 4'b0010, 1'b0, T_IF), $sformatf("rst_hold%0d", k));
        end
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        run_instr("post_rst_add", 32'h002081B3, 1'b0, C_R, 4'b0010);

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
